xs_cpu_rst_seq: RTL

CPU reset sequencer for the FPGA top. It sits between the board reset and button inputs and the core's `cpu_rstn` and peripheral resets. It replaces the bare debounce-plus-flop path with:
- a synchronised, debounced button,
- a wait for DDR calibration (with an optional timeout),
- a fixed peripheral-before-CPU release hold.

It drives `cpu_rstn` and `periph_rstn` of `xs_core_def` and exposes its state for LEDs and ILA.

---
 rtl/xs_cpu_rst_seq_if.sv | 29 ++
 rtl/xs_cpu_rst_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/xs_cpu_rst_seq_if.sv
// rtl/xs_cpu_rst_seq_if.sv - board-side button/calibration inputs and reset/status outputs of the CPU reset sequencer
interface xs_cpu_rst_seq_if;
   logic       button_i;
   logic       calib_done;
   logic       cpu_rstn;
   logic       periph_rstn;
   logic [1:0] seq_state;
   logic       calib_timeout;

   // Board/stimulus side: drives the raw inputs, observes the resets
   modport master (
      output button_i,
      output calib_done,
      input  cpu_rstn,
      input  periph_rstn,
      input  seq_state,
      input  calib_timeout
   );

   // Sequencer side
   modport slave (
      input  button_i,
      input  calib_done,
      output cpu_rstn,
      output periph_rstn,
      output seq_state,
      output calib_timeout
   );
endinterface

// File: rtl/xs_cpu_rst_seq.sv
// rtl/xs_cpu_rst_seq.sv - CPU reset sequencer: button debounce, DDR calibration wait, peripheral-before-CPU release
module xs_cpu_rst_seq #(
   parameter int DEB_CYCLES    = 1000000,
   parameter int HOLD_CYCLES   = 64,
   parameter int CALIB_TIMEOUT = 0
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst,
   xs_cpu_rst_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALIB = 2'd1,
      HOLD  = 2'd2,
      RUN   = 2'd3
   } state_t;

   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TO_W   = (CALIB_TIMEOUT > 2) ? $clog2(CALIB_TIMEOUT) : 1;
   localparam bit TO_EN  = (CALIB_TIMEOUT != 0);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((CALIB_TIMEOUT == 0) ? 0 : CALIB_TIMEOUT - 1);

   logic              btn_meta_q;
   logic              btn_s_q;
   logic              cal_meta_q;
   logic              cal_s_q;
   logic              btn_db_q;
   logic              btn_db_prev_q;
   logic [DEB_W-1:0]  deb_cnt_q;
   logic              rise_d;
   logic              fall_d;

   state_t            state_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              cpu_rstn_q;
   logic              periph_rstn_q;
   logic              calib_timeout_q;

   // Two-flop synchronisers for the asynchronous button and calibration inputs
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst) begin
         btn_meta_q <= 1'b0;
         btn_s_q    <= 1'b0;
         cal_meta_q <= 1'b0;
         cal_s_q    <= 1'b0;
      end else begin
         btn_meta_q <= bus.button_i;
         btn_s_q    <= btn_meta_q;
         cal_meta_q <= bus.calib_done;
         cal_s_q    <= cal_meta_q;
      end
   end

   // Debounce: the level only follows btn_s after DEB_CYCLES consecutive mismatching cycles
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst) begin
         btn_db_q      <= 1'b0;
         btn_db_prev_q <= 1'b0;
         deb_cnt_q     <= '0;
      end else begin
         btn_db_prev_q <= btn_db_q;
         if (btn_s_q == btn_db_q) begin
            deb_cnt_q <= '0;
         end else if (deb_cnt_q == DEB_LAST) begin
            btn_db_q  <= btn_s_q;
            deb_cnt_q <= '0;
         end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
         end
      end
   end

   // Edge pulses of the debounced level; resetting btn_db to 0 makes a released button start the CPU
   assign rise_d = btn_db_q & ~btn_db_prev_q;
   assign fall_d = ~btn_db_q & btn_db_prev_q;

   // Sequencer FSM; the reset outputs are registered as the decode of the next state
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst) begin
         state_q         <= IDLE;
         hold_cnt_q      <= '0;
         to_cnt_q        <= '0;
         cpu_rstn_q      <= 1'b0;
         periph_rstn_q   <= 1'b0;
         calib_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cpu_rstn_q    <= 1'b0;
               periph_rstn_q <= 1'b0;
               if (rise_d) begin
                  state_q  <= CALIB;
                  to_cnt_q <= '0;
               end
            end
            CALIB: begin
               to_cnt_q <= to_cnt_q + TO_W'(1);
               // A calibration that lands on the timeout cycle still counts as success
               if (cal_s_q) begin
                  state_q       <= HOLD;
                  hold_cnt_q    <= '0;
                  periph_rstn_q <= 1'b1;
                  cpu_rstn_q    <= 1'b0;
               end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                  state_q         <= IDLE;
                  calib_timeout_q <= 1'b1;
               end else if (fall_d) begin
                  state_q <= IDLE;
               end
            end
            HOLD: begin
               // Losing calibration or a press aborts even on the completion cycle
               if (fall_d || !cal_s_q) begin
                  state_q       <= IDLE;
                  periph_rstn_q <= 1'b0;
                  cpu_rstn_q    <= 1'b0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q    <= RUN;
                  cpu_rstn_q <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
            end
            RUN: begin
               if (fall_d || !cal_s_q) begin
                  state_q       <= IDLE;
                  periph_rstn_q <= 1'b0;
                  cpu_rstn_q    <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               periph_rstn_q <= 1'b0;
               cpu_rstn_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_rstn      = cpu_rstn_q;
   assign bus.periph_rstn   = periph_rstn_q;
   assign bus.seq_state     = state_q;
   assign bus.calib_timeout = calib_timeout_q;

endmodule
